// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM driver.
//   motor_state_t : per-wheel FSM state, encoding is visible on the
//                   stateLeft/stateRight ports (IDLE=0, RAMP_UP=1, RUN=2,
//                   RAMP_DOWN=3).
//   DEF_*         : default parameter values used by the driver and channel.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } motor_state_t;

    localparam int unsigned DEF_PWM_W     = 8;
    localparam int unsigned DEF_DUTY_MAX  = 255;
    localparam int unsigned DEF_STEP      = 16;
    localparam int unsigned DEF_RAMP_DIV  = 4;
    localparam int unsigned DEF_BRAKE_CYC = 16;

endpackage

// File: rtl/motor_pwm_channel.sv
// One wheel channel: run/stop FSM, ramped duty register, registered PWM
// compare against the shared counter and (optionally) a brake pulse.
// Optional feature macro: MOTOR_BRAKE_EN (hard stop with brake pulse instead
// of the soft ramp-down).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   cmd         : run command (1 = run), sampled every clock
//   tick        : ramp tick from the driver (last cycle of a ramp period)
//   pwm_cnt     : shared PWM counter
//   pwm         : registered PWM output, one cycle behind the compare
//   duty        : current duty
//   state       : FSM state
//   brake       : brake pulse (MOTOR_BRAKE_EN only)
module motor_pwm_channel
    import motor_pkg::*;
#(
    parameter int unsigned PWM_W    = DEF_PWM_W,
    parameter int unsigned DUTY_MAX = DEF_DUTY_MAX,
    parameter int unsigned STEP     = DEF_STEP
`ifdef MOTOR_BRAKE_EN
    ,
    parameter int unsigned BRAKE_CYC = DEF_BRAKE_CYC
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd,
    input  logic             tick,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             pwm,
    output logic [PWM_W-1:0] duty,
    output motor_state_t     state
`ifdef MOTOR_BRAKE_EN
    ,
    output logic             brake
`endif
);

    localparam logic [PWM_W:0]   STEP_X = (PWM_W+1)'(STEP);
    localparam logic [PWM_W:0]   MAX_X  = (PWM_W+1)'(DUTY_MAX);
    localparam logic [PWM_W-1:0] MAX_D  = PWM_W'(DUTY_MAX);

    // Ramp arithmetic is one bit wider than the duty so it can saturate
    // instead of wrapping.
    logic [PWM_W:0]   duty_x, up_sum, down_diff;
    logic [PWM_W-1:0] up_val, down_val;

    always_comb begin
        duty_x    = {1'b0, duty};
        up_sum    = duty_x + STEP_X;
        down_diff = duty_x - STEP_X;
        up_val    = (up_sum > MAX_X) ? MAX_D : up_sum[PWM_W-1:0];
        down_val  = (duty_x > STEP_X) ? down_diff[PWM_W-1:0] : '0;
    end

`ifdef MOTOR_BRAKE_EN
    localparam int unsigned BCW = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
    logic [BCW-1:0] brake_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            duty  <= '0;
            pwm   <= 1'b0;
`ifdef MOTOR_BRAKE_EN
            brake     <= 1'b0;
            brake_cnt <= '0;
`endif
        end else begin
            // Duty only moves on the tick at the last count of a period,
            // so the compare never sees a mid-period change.
            pwm <= (pwm_cnt < duty);
            case (state)
                IDLE: begin
`ifdef MOTOR_BRAKE_EN
                    // A pulse only ever runs while IDLE; a new run
                    // command cuts it short.
                    if (brake) begin
                        if (cmd || brake_cnt == '0) brake <= 1'b0;
                        else                        brake_cnt <= brake_cnt - 1'b1;
                    end
`endif
                    if (cmd) state <= RAMP_UP;
                end
                RAMP_UP: begin
`ifdef MOTOR_BRAKE_EN
                    if (!cmd) begin
                        duty      <= '0;
                        state     <= IDLE;
                        brake     <= 1'b1;
                        brake_cnt <= BCW'(BRAKE_CYC - 1);
                    end else if (tick) begin
                        duty <= up_val;
                        if (up_val == MAX_D) state <= RUN;
                    end
`else
                    if (tick) duty <= up_val;
                    if (!cmd)                           state <= RAMP_DOWN;
                    else if (tick && up_val == MAX_D)   state <= RUN;
`endif
                end
                RUN: begin
`ifdef MOTOR_BRAKE_EN
                    if (!cmd) begin
                        duty      <= '0;
                        state     <= IDLE;
                        brake     <= 1'b1;
                        brake_cnt <= BCW'(BRAKE_CYC - 1);
                    end else begin
                        duty <= MAX_D;
                    end
`else
                    duty <= MAX_D;
                    if (!cmd) state <= RAMP_DOWN;
`endif
                end
                RAMP_DOWN: begin
                    if (tick) duty <= down_val;
                    if (cmd)                          state <= RAMP_UP;
                    else if (tick && down_val == '0)  state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// Two-wheel soft-start/soft-stop PWM driver between the line-follower FSM
// and the H-bridge. Holds the shared PWM counter and the ramp divider and
// instantiates one motor_pwm_channel per wheel.
// Optional feature macro: MOTOR_BRAKE_EN (adds brakeLeft/brakeRight).
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   motorLeft, motorRight   : wheel run commands
//   pwmLeft, pwmRight       : wheel PWM outputs
//   dutyLeft, dutyRight     : current duties
//   stateLeft, stateRight   : FSM states (IDLE=0 RAMP_UP=1 RUN=2 RAMP_DOWN=3)
//   brakeLeft, brakeRight   : brake pulses (MOTOR_BRAKE_EN only)
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int unsigned PWM_W     = DEF_PWM_W,
    parameter int unsigned DUTY_MAX  = DEF_DUTY_MAX,
    parameter int unsigned STEP      = DEF_STEP,
    parameter int unsigned RAMP_DIV  = DEF_RAMP_DIV,
    parameter int unsigned BRAKE_CYC = DEF_BRAKE_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             motorLeft,
    input  logic             motorRight,
    output logic             pwmLeft,
    output logic             pwmRight,
    output logic [PWM_W-1:0] dutyLeft,
    output logic [PWM_W-1:0] dutyRight,
    output logic [1:0]       stateLeft,
    output logic [1:0]       stateRight
`ifdef MOTOR_BRAKE_EN
    ,
    output logic             brakeLeft,
    output logic             brakeRight
`endif
);

    if (DUTY_MAX >= (1 << PWM_W) || STEP == 0 || RAMP_DIV == 0 || BRAKE_CYC == 0) begin : g_bad_cfg
        $error("motor_pwm_driver: illegal parameter combination");
    end

    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PWM_W-1:0] pwm_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             period_end, div_last, ramp_tick;
    motor_state_t     state_left, state_right;

    assign period_end = (pwm_cnt == '1);
    assign div_last   = (div_cnt == DIV_W'(RAMP_DIV - 1));
    assign ramp_tick  = period_end && div_last;
    assign stateLeft  = state_left;
    assign stateRight = state_right;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            div_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (period_end) div_cnt <= div_last ? '0 : div_cnt + 1'b1;
        end
    end

    motor_pwm_channel #(
        .PWM_W    (PWM_W),
        .DUTY_MAX (DUTY_MAX),
        .STEP     (STEP)
`ifdef MOTOR_BRAKE_EN
        ,
        .BRAKE_CYC(BRAKE_CYC)
`endif
    ) u_left (
        .clk     (clk),
        .reset   (reset),
        .cmd     (motorLeft),
        .tick    (ramp_tick),
        .pwm_cnt (pwm_cnt),
        .pwm     (pwmLeft),
        .duty    (dutyLeft),
        .state   (state_left)
`ifdef MOTOR_BRAKE_EN
        ,
        .brake   (brakeLeft)
`endif
    );

    motor_pwm_channel #(
        .PWM_W    (PWM_W),
        .DUTY_MAX (DUTY_MAX),
        .STEP     (STEP)
`ifdef MOTOR_BRAKE_EN
        ,
        .BRAKE_CYC(BRAKE_CYC)
`endif
    ) u_right (
        .clk     (clk),
        .reset   (reset),
        .cmd     (motorRight),
        .tick    (ramp_tick),
        .pwm_cnt (pwm_cnt),
        .pwm     (pwmRight),
        .duty    (dutyRight),
        .state   (state_right)
`ifdef MOTOR_BRAKE_EN
        ,
        .brake   (brakeRight)
`endif
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Testbench for motor_pwm_driver (PWM_W=4, DUTY_MAX=15, STEP=4, RAMP_DIV=1).
// Directed scenarios plus randomized commands against a cycle-level
// reference model computed from the ramp rules with integer arithmetic.
module tb_motor_pwm_driver;

    localparam int PWM_W     = 4;
    localparam int DUTY_MAX  = 15;
    localparam int STEP      = 4;
    localparam int RAMP_DIV  = 1;
    localparam int BRAKE_CYC = 16;
    localparam int PERIOD    = 1 << PWM_W;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motorLeft = 1'b0;
    logic       motorRight = 1'b0;
    logic       pwmLeft, pwmRight;
    logic [3:0] dutyLeft, dutyRight;
    logic [1:0] stateLeft, stateRight;
`ifdef MOTOR_BRAKE_EN
    logic       brakeLeft, brakeRight;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .PWM_W    (PWM_W),
        .DUTY_MAX (DUTY_MAX),
        .STEP     (STEP),
        .RAMP_DIV (RAMP_DIV),
        .BRAKE_CYC(BRAKE_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .motorLeft  (motorLeft),
        .motorRight (motorRight),
        .pwmLeft    (pwmLeft),
        .pwmRight   (pwmRight),
        .dutyLeft   (dutyLeft),
        .dutyRight  (dutyRight),
        .stateLeft  (stateLeft),
        .stateRight (stateRight)
`ifdef MOTOR_BRAKE_EN
        ,
        .brakeLeft  (brakeLeft),
        .brakeRight (brakeRight)
`endif
    );

    // Reference model: period position, period index, per-wheel mode/duty.
    int   m_cnt = 0;
    int   m_periods = 0;
    bit   m_tick = 0;
    int   m_state [2] = '{0, 0};
    int   m_duty  [2] = '{0, 0};
    int   m_brem  [2] = '{0, 0};
    logic m_pwm   [2] = '{1'b0, 1'b0};

    task automatic model_edge();
        int  old_cnt;
        bit  cmd;
        old_cnt = m_cnt;
        if (reset) begin
            m_cnt = 0; m_periods = 0; m_tick = 0;
            for (int c = 0; c < 2; c++) begin
                m_state[c] = 0; m_duty[c] = 0; m_brem[c] = 0; m_pwm[c] = 1'b0;
            end
            return;
        end
        m_tick = (old_cnt == PERIOD - 1) && (m_periods % RAMP_DIV == RAMP_DIV - 1);
        if (old_cnt == PERIOD - 1) m_periods++;
        m_cnt = (old_cnt + 1) % PERIOD;
        for (int c = 0; c < 2; c++) begin
            cmd = (c == 0) ? motorLeft : motorRight;
            m_pwm[c] = (old_cnt < m_duty[c]);
            if (m_state[c] == 0) begin
                if (m_brem[c] > 0) m_brem[c] = cmd ? 0 : m_brem[c] - 1;
                if (cmd) m_state[c] = 1;
            end else if (m_state[c] == 1 || m_state[c] == 2) begin
`ifdef MOTOR_BRAKE_EN
                if (!cmd) begin
                    m_duty[c] = 0; m_state[c] = 0; m_brem[c] = BRAKE_CYC;
                    continue;
                end
`endif
                if (m_state[c] == 2) m_duty[c] = DUTY_MAX;
                else if (m_tick) begin
                    m_duty[c] = (m_duty[c] + STEP > DUTY_MAX) ? DUTY_MAX : m_duty[c] + STEP;
                end
                if (!cmd) m_state[c] = 3;
                else if (m_state[c] == 1 && m_tick && m_duty[c] == DUTY_MAX) m_state[c] = 2;
            end else begin
                if (m_tick) m_duty[c] = (m_duty[c] > STEP) ? m_duty[c] - STEP : 0;
                if (cmd) m_state[c] = 1;
                else if (m_tick && m_duty[c] == 0) m_state[c] = 0;
            end
        end
    endtask

    // Advance one clock; outputs are settled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset(input logic left, input logic right);
        reset = 1'b1; motorLeft = left; motorRight = right;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        motorLeft = 1'b1; motorRight = 1'b1; reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({pwmLeft, pwmRight, dutyLeft, dutyRight, stateLeft, stateRight} !== 14'd0) begin
                errors++;
                $display("FAIL reset_outputs got pwm=%b%b duty=%0d/%0d state=%0d/%0d exp all 0",
                         pwmLeft, pwmRight, dutyLeft, dutyRight, stateLeft, stateRight);
            end
`ifdef MOTOR_BRAKE_EN
            checks++;
            if ({brakeLeft, brakeRight} !== 2'b00) begin
                errors++;
                $display("FAIL reset_brake got %b%b exp 00", brakeLeft, brakeRight);
            end
`endif
        end
        reset = 1'b0;
        step();
        checks++;
        if (stateLeft !== 2'd1 || stateRight !== 2'd1) begin
            errors++;
            $display("FAIL release_state got %0d/%0d exp 1/1", stateLeft, stateRight);
        end
        checks++;
        if (dutyLeft !== 4'd0 || dutyRight !== 4'd0) begin
            errors++;
            $display("FAIL release_duty got %0d/%0d exp 0/0", dutyLeft, dutyRight);
        end
    endtask

    task automatic test_ramp_up();
        int exp_duty [4] = '{4, 8, 12, 15};
        int seen = 0;
        int highs = 0;
        apply_reset(1'b1, 1'b0);
        for (int i = 0; i < 6 * PERIOD && seen < 4; i++) begin
            step();
            if (m_tick) begin
                checks++;
                if (dutyLeft !== 4'(exp_duty[seen])) begin
                    errors++;
                    $display("FAIL ramp_up_duty step=%0d got %0d exp %0d", seen, dutyLeft, exp_duty[seen]);
                end
                checks++;
                if (stateLeft !== ((seen == 3) ? 2'd2 : 2'd1)) begin
                    errors++;
                    $display("FAIL ramp_up_state step=%0d got %0d exp %0d", seen, stateLeft, (seen == 3) ? 2 : 1);
                end
                seen++;
            end
        end
        checks++;
        if (seen != 4) begin
            errors++;
            $display("FAIL ramp_up_timeout got %0d steps exp 4", seen);
        end
        for (int i = 0; i < PERIOD; i++) begin
            step();
            highs += int'(pwmLeft);
        end
        checks++;
        if (highs != 15) begin
            errors++;
            $display("FAIL run_pwm_highs got %0d exp 15", highs);
        end
    endtask

`ifndef MOTOR_BRAKE_EN
    task automatic test_ramp_down();
        int exp_duty [4] = '{11, 7, 3, 0};
        int seen = 0;
        int highs = 0;
        motorLeft = 1'b0;
        step();
        checks++;
        if (stateLeft !== 2'd3 || dutyLeft !== 4'd15) begin
            errors++;
            $display("FAIL drop_enter got state=%0d duty=%0d exp state=3 duty=15", stateLeft, dutyLeft);
        end
        for (int i = 0; i < 6 * PERIOD && seen < 4; i++) begin
            step();
            if (m_tick) begin
                checks++;
                if (dutyLeft !== 4'(exp_duty[seen]) || stateLeft !== ((seen == 3) ? 2'd0 : 2'd3)) begin
                    errors++;
                    $display("FAIL ramp_down step=%0d got duty=%0d state=%0d exp duty=%0d state=%0d",
                             seen, dutyLeft, stateLeft, exp_duty[seen], (seen == 3) ? 0 : 3);
                end
                seen++;
            end
        end
        checks++;
        if (seen != 4) begin
            errors++;
            $display("FAIL ramp_down_timeout got %0d steps exp 4", seen);
        end
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step();
            highs += int'(pwmLeft);
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL idle_pwm_highs got %0d exp 0", highs);
        end
    endtask

    task automatic test_reversal();
        bit hit = 0;
        apply_reset(1'b1, 1'b0);
        for (int i = 0; i < 6 * PERIOD && !hit; i++) begin
            step();
            hit = (dutyLeft == 4'd8);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reversal_reach8 got duty=%0d exp 8", dutyLeft);
        end
        motorLeft = 1'b0;
        step();
        checks++;
        if (stateLeft !== 2'd3 || dutyLeft !== 4'd8) begin
            errors++;
            $display("FAIL reversal_drop got state=%0d duty=%0d exp state=3 duty=8", stateLeft, dutyLeft);
        end
        hit = 0;
        for (int i = 0; i < 2 * PERIOD && !hit; i++) begin step(); hit = m_tick; end
        checks++;
        if (stateLeft !== 2'd3 || dutyLeft !== 4'd4) begin
            errors++;
            $display("FAIL reversal_down got state=%0d duty=%0d exp state=3 duty=4", stateLeft, dutyLeft);
        end
        motorLeft = 1'b1;
        step();
        checks++;
        if (stateLeft !== 2'd1 || dutyLeft !== 4'd4) begin
            errors++;
            $display("FAIL reversal_raise got state=%0d duty=%0d exp state=1 duty=4", stateLeft, dutyLeft);
        end
        hit = 0;
        for (int i = 0; i < 2 * PERIOD && !hit; i++) begin step(); hit = m_tick; end
        checks++;
        if (stateLeft !== 2'd1 || dutyLeft !== 4'd8) begin
            errors++;
            $display("FAIL reversal_up got state=%0d duty=%0d exp state=1 duty=8", stateLeft, dutyLeft);
        end
    endtask
`endif

    task automatic test_idle_channel();
        apply_reset(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if (pwmRight !== 1'b0 || dutyRight !== 4'd0 || stateRight !== 2'd0) begin
                errors++;
                $display("FAIL idle_right cyc=%0d got pwm=%b duty=%0d state=%0d exp 0/0/0",
                         i, pwmRight, dutyRight, stateRight);
            end
        end
        checks++;
        if (dutyLeft !== 4'd15 || stateLeft !== 2'd2) begin
            errors++;
            $display("FAIL idle_left_run got duty=%0d state=%0d exp duty=15 state=2", dutyLeft, stateLeft);
        end
    endtask

    task automatic test_reset_mid_run();
        motorRight = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({pwmLeft, pwmRight, dutyLeft, dutyRight, stateLeft, stateRight} !== 14'd0) begin
            errors++;
            $display("FAIL mid_run_reset got pwm=%b%b duty=%0d/%0d state=%0d/%0d exp all 0",
                     pwmLeft, pwmRight, dutyLeft, dutyRight, stateLeft, stateRight);
        end
    endtask

`ifdef MOTOR_BRAKE_EN
    task automatic test_brake();
        int highs;
        apply_reset(1'b1, 1'b0);
        for (int i = 0; i < 5 * PERIOD; i++) step();
        checks++;
        if (stateLeft !== 2'd2) begin
            errors++;
            $display("FAIL brake_pre_run got state=%0d exp 2", stateLeft);
        end
        motorLeft = 1'b0;
        step();
        checks++;
        if (dutyLeft !== 4'd0 || stateLeft !== 2'd0 || brakeLeft !== 1'b1) begin
            errors++;
            $display("FAIL brake_start got duty=%0d state=%0d brake=%b exp 0/0/1", dutyLeft, stateLeft, brakeLeft);
        end
        highs = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            highs += int'(brakeLeft);
        end
        checks++;
        if (highs != BRAKE_CYC) begin
            errors++;
            $display("FAIL brake_len got %0d exp %0d", highs, BRAKE_CYC);
        end
        motorLeft = 1'b1;
        for (int i = 0; i < 5 * PERIOD; i++) step();
        motorLeft = 1'b0;
        step(); step(); step();
        motorLeft = 1'b1;
        step();
        checks++;
        if (brakeLeft !== 1'b0 || stateLeft !== 2'd1) begin
            errors++;
            $display("FAIL brake_abort got brake=%b state=%0d exp 0/1", brakeLeft, stateLeft);
        end
    endtask
`endif

    task automatic test_random();
        int hold_l = 0;
        int hold_r = 0;
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (hold_l == 0) begin motorLeft  = 1'($urandom_range(0, 1)); hold_l = $urandom_range(1, 120); end
            if (hold_r == 0) begin motorRight = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 120); end
            hold_l--; hold_r--;
            reset = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if ({pwmLeft, dutyLeft, stateLeft} !== {m_pwm[0], 4'(m_duty[0]), 2'(m_state[0])}) begin
                errors++;
                $display("FAIL rand_left cyc=%0d got pwm=%b duty=%0d state=%0d exp pwm=%b duty=%0d state=%0d",
                         i, pwmLeft, dutyLeft, stateLeft, m_pwm[0], m_duty[0], m_state[0]);
            end
            checks++;
            if ({pwmRight, dutyRight, stateRight} !== {m_pwm[1], 4'(m_duty[1]), 2'(m_state[1])}) begin
                errors++;
                $display("FAIL rand_right cyc=%0d got pwm=%b duty=%0d state=%0d exp pwm=%b duty=%0d state=%0d",
                         i, pwmRight, dutyRight, stateRight, m_pwm[1], m_duty[1], m_state[1]);
            end
`ifdef MOTOR_BRAKE_EN
            checks++;
            if ({brakeLeft, brakeRight} !== {1'(m_brem[0] > 0), 1'(m_brem[1] > 0)}) begin
                errors++;
                $display("FAIL rand_brake cyc=%0d got %b%b exp %b%b", i, brakeLeft, brakeRight,
                         m_brem[0] > 0, m_brem[1] > 0);
            end
`endif
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
`ifndef MOTOR_BRAKE_EN
        test_ramp_down();
        test_reversal();
`endif
        test_idle_channel();
        test_reset_mid_run();
`ifdef MOTOR_BRAKE_EN
        test_brake();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
